fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RD_LAT, default 2, SHALL set instruction-memory read latency in cycles, legal range 1..15.
REQ-002 Parameter RESET_PC, default 64'h0, SHALL set the first fetch address after reset.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset_L  in  1  SHALL be asynchronous, active-low reset.
REQ-005 FetchEn  in  1  SHALL enable the start of new fetches.
REQ-006 IMemAddress  out  64  SHALL be the registered address driven to instruction memory.
REQ-007 IMemData  in  32  SHALL be the instruction word returned by instruction memory.
REQ-008 Redirect  in  1  SHALL request a PC change (branch/exception).
REQ-009 RedirectPC  in  64  SHALL be the redirect target, sampled when Redirect=1.
REQ-010 InstrValid  out  1  SHALL flag that Instr/InstrPC hold a valid fetched instruction.
REQ-011 InstrReady  in  1  SHALL be the consumer's acceptance signal.
REQ-012 Instr  out  32  SHALL be the captured instruction word.
REQ-013 InstrPC  out  64  SHALL be the address Instr was fetched from.
REQ-014 FetchCount  out  32  SHALL count accepted instructions.

Function
REQ-015 States SHALL be IDLE, WAIT, HOLD; a latency counter (4 bits) SHALL run only in WAIT.
REQ-016 IMemAddress SHALL equal the internal PC and SHALL stay stable for the whole of WAIT.
REQ-017 IDLE: FetchEn=1 -> WAIT with counter=0; otherwise stay IDLE.
REQ-018 WAIT: counter increments each cycle; on the cycle counter==RD_LAT-1, Instr<=IMemData, InstrPC<=PC, PC<=PC+4, InstrValid<=1, next state HOLD.
REQ-019 Latency SHALL be exactly RD_LAT cycles from WAIT entry to InstrValid=1.
REQ-020 A transfer SHALL occur on any edge with InstrValid=1 and InstrReady=1; FetchCount SHALL increment by 1 (mod 2^32).
REQ-021 HOLD: without transfer, Instr, InstrPC, InstrValid and IMemAddress SHALL hold; with transfer, InstrValid<=0 and next state WAIT (counter=0) if FetchEn=1, else IDLE.
REQ-022 FetchEn deasserted during WAIT SHALL NOT abort the fetch; the sequencer completes to HOLD and goes IDLE after transfer.
REQ-023 Redirect=1 in any state SHALL set PC<={RedirectPC[63:2],2'b00}, InstrValid<=0, counter<=0, next state WAIT if FetchEn=1 else IDLE; any in-flight fetch is discarded.
REQ-024 Redirect SHALL have priority over WAIT completion and HOLD transitions; a transfer in the same cycle as Redirect SHALL still count in FetchCount.
REQ-025 PC+4 SHALL wrap modulo 2^64 with no flag.
REQ-026 Instr SHALL capture IMemData unchanged, including X values; no decode or checking.
REQ-027 Throughput SHALL be one instruction per RD_LAT+1 cycles with InstrReady held high.

Reset
REQ-028 Reset_L=0 SHALL immediately, without a clock edge, force state=IDLE, PC=IMemAddress=RESET_PC, counter=0, InstrValid=0, Instr=32'h0, InstrPC=64'h0, FetchCount=0.
REQ-029 Reset deassertion SHALL take effect on the first rising CLK edge with Reset_L=1; a fetch mid-flight at reset SHALL be lost.

Verification (RD_LAT=2, RESET_PC=0, memory model returns fixed words per address)
REQ-030 Reset, FetchEn=1, InstrReady=1, mem[0]=F84003E9, mem[4]=F84083EA -> InstrValid=1 two cycles after WAIT entry with Instr=F84003E9, InstrPC=0; next Instr=F84083EA, InstrPC=4 three cycles later; FetchCount=2.
REQ-031 InstrReady=0 for 5 cycles while InstrValid=1 -> Instr, InstrPC=0, IMemAddress=4 all constant; FetchCount unchanged; after InstrReady=1, fetch of address 4 begins.
REQ-032 Redirect=1, RedirectPC=64'h2E in the first WAIT cycle -> IMemAddress=0x2C next cycle, original fetch never presented, next InstrPC=0x2C, Instr=mem[0x2C].
REQ-033 Redirect=1 (RedirectPC=0x1C) in the same cycle as a transfer in HOLD -> FetchCount increments, InstrValid=0 next cycle, next InstrPC=0x1C.
REQ-034 Reset_L pulsed low between clock edges during WAIT -> all outputs reach reset values before the next edge; fetch restarts at address 0.
REQ-035 Redirect to 64'hFFFF_FFFF_FFFF_FFFC, then transfer -> InstrPC=FFFF_FFFF_FFFF_FFFC, then IMemAddress=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one registered fetch address, waits RD_LAT
// cycles for memory, then holds the captured word until the consumer accepts it.
//
// state | meaning
// IDLE  | no fetch in flight, waiting for FetchEn
// WAIT  | address presented, latency counter running
// HOLD  | Instr/InstrPC valid, waiting for InstrReady
module fetch_sequencer #(
  parameter int unsigned RD_LAT   = 2,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        FetchEn,
  output logic [63:0] IMemAddress,
  input  logic [31:0] IMemData,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  localparam logic [3:0] LAST_CNT = 4'(RD_LAT - 1);

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        valid, valid_nxt;
  logic [31:0] instr, instr_nxt;
  logic [63:0] instr_pc, instr_pc_nxt;
  logic [31:0] count, count_nxt;
  logic        transfer;

  assign transfer = valid & InstrReady;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      cnt      <= 4'd0;
      valid    <= 1'b0;
      instr    <= 32'h0;
      instr_pc <= 64'h0;
      count    <= 32'h0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      cnt      <= cnt_nxt;
      valid    <= valid_nxt;
      instr    <= instr_nxt;
      instr_pc <= instr_pc_nxt;
      count    <= count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    cnt_nxt      = cnt;
    valid_nxt    = valid;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    count_nxt    = count;

    // An accepted word counts even when a redirect discards the FSM's next step
    if (transfer) count_nxt = count + 32'd1;

    if (Redirect) begin
      pc_nxt    = {RedirectPC[63:2], 2'b00};
      valid_nxt = 1'b0;
      cnt_nxt   = 4'd0;
      state_nxt = FetchEn ? WAIT : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (FetchEn) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'd0;
          end
        end
        WAIT: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            instr_nxt    = IMemData;
            instr_pc_nxt = pc;
            pc_nxt       = pc + 64'd4;
            valid_nxt    = 1'b1;
            cnt_nxt      = 4'd0;
            state_nxt    = HOLD;
          end
        end
        HOLD: begin
          if (transfer) begin
            valid_nxt = 1'b0;
            cnt_nxt   = 4'd0;
            state_nxt = FetchEn ? WAIT : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign IMemAddress = pc;
  assign InstrValid  = valid;
  assign Instr       = instr;
  assign InstrPC     = instr_pc;
  assign FetchCount  = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic, all
// checked every cycle against a deadline-based transaction model.
module tb_fetch_sequencer;

  localparam int RD_LAT = 2;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        FetchEn;
  logic [63:0] IMemAddress;
  logic [31:0] IMemData;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic [31:0] FetchCount;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: fetch in flight with a capture deadline, or a held word
  longint      cyc;
  logic [63:0] m_pc;
  logic        m_busy;
  longint      m_due;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_instr_pc;
  logic [31:0] m_count;

  fetch_sequencer #(.RD_LAT(RD_LAT), .RESET_PC(64'h0)) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .FetchEn    (FetchEn),
    .IMemAddress(IMemAddress),
    .IMemData   (IMemData),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .FetchCount (FetchCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'hF84003E9;
    if (a == 64'h4) return 32'hF84083EA;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
  endfunction

  assign IMemData = mem_word(IMemAddress);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = 64'h0;
    m_busy     = 1'b0;
    m_due      = 0;
    m_valid    = 1'b0;
    m_instr    = 32'h0;
    m_instr_pc = 64'h0;
    m_count    = 32'h0;
  endtask

  task automatic model_edge();
    logic xfer;
    xfer = m_valid && InstrReady;
    if (xfer) m_count = m_count + 32'd1;
    if (Redirect) begin
      m_pc    = {RedirectPC[63:2], 2'b00};
      m_valid = 1'b0;
      m_busy  = FetchEn;
      m_due   = cyc + RD_LAT;
    end else if (m_busy) begin
      if (cyc == m_due) begin
        m_instr    = mem_word(m_pc);
        m_instr_pc = m_pc;
        m_pc       = m_pc + 64'd4;
        m_valid    = 1'b1;
        m_busy     = 1'b0;
      end
    end else if (m_valid) begin
      if (xfer) begin
        m_valid = 1'b0;
        m_busy  = FetchEn;
        m_due   = cyc + RD_LAT;
      end
    end else if (FetchEn) begin
      m_busy = 1'b1;
      m_due  = cyc + RD_LAT;
    end
  endtask

  task automatic check_all();
    chk("imem_addr",   IMemAddress,        m_pc);
    chk("instr_valid", 64'(InstrValid),    64'(m_valid));
    chk("instr",       64'(Instr),         64'(m_instr));
    chk("instr_pc",    InstrPC,            m_instr_pc);
    chk("fetch_count", 64'(FetchCount),    64'(m_count));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  // reset pulse entirely between two rising edges
  task automatic async_reset();
    @(negedge CLK);
    Reset_L = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    Reset_L = 1'b1;
  endtask

  initial begin
    cyc        = 0;
    Reset_L    = 1'b0;
    FetchEn    = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 64'h0;
    InstrReady = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    Reset_L = 1'b1;

    // back-to-back fetches with consumer always ready
    FetchEn    = 1'b1;
    InstrReady = 1'b1;
    step();
    step();
    chk("first_not_early", 64'(InstrValid), 64'd0);
    step();
    chk("first_instr", 64'(Instr), 64'hF84003E9);
    chk("first_pc", InstrPC, 64'h0);
    step();
    step();
    step();
    chk("second_instr", 64'(Instr), 64'hF84083EA);
    chk("second_pc", InstrPC, 64'h4);
    step();
    chk("count_two", 64'(FetchCount), 64'd2);

    // consumer stalls while a word is held
    InstrReady = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_pc", InstrPC, 64'h8);
      chk("stall_addr", IMemAddress, 64'hC);
      chk("stall_count", 64'(FetchCount), 64'd2);
    end

    // redirect coinciding with a transfer
    InstrReady = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 64'h1C;
    step();
    chk("redir_xfer_count", 64'(FetchCount), 64'd3);
    chk("redir_xfer_valid", 64'(InstrValid), 64'd0);
    Redirect = 1'b0;
    step();
    step();
    chk("redir_xfer_pc", InstrPC, 64'h1C);

    // redirect in the first WAIT cycle discards the in-flight fetch
    step();
    Redirect   = 1'b1;
    RedirectPC = 64'h2E;
    step();
    chk("redir_wait_addr", IMemAddress, 64'h2C);
    Redirect = 1'b0;
    step();
    step();
    chk("redir_wait_pc", InstrPC, 64'h2C);
    chk("redir_wait_instr", 64'(Instr), 64'(mem_word(64'h2C)));

    // PC wraps past the top of the address space
    Redirect   = 1'b1;
    RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    Redirect = 1'b0;
    step();
    step();
    chk("wrap_pc", InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", IMemAddress, 64'h0);
    step();

    // async reset during WAIT, then restart from the reset PC
    step();
    async_reset();
    chk("rst_count", 64'(FetchCount), 64'd0);
    step();
    step();
    step();
    chk("restart_pc", InstrPC, 64'h0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      FetchEn    = ($urandom_range(0, 9) != 0);
      InstrReady = ($urandom_range(0, 2) != 0);
      Redirect   = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0:       RedirectPC = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        1:       RedirectPC = 64'($urandom_range(0, 255));
        default: RedirectPC = {$urandom, $urandom};
      endcase
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
